// File: rtl/tap_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : tap_pkg
//  Purpose  : Shared TAP state encodings, command opcodes, sequencer FSM
//             states and the IEEE 1149.1 next-state function.
//  Revision : 1.0  initial release
// ============================================================================
package tap_pkg;

   // 16-state TAP controller encoding shared with the state mirror
   localparam logic [3:0] c_TAP_TLR      = 4'h0;
   localparam logic [3:0] c_TAP_RTI      = 4'h1;
   localparam logic [3:0] c_TAP_SEL_DR   = 4'h2;
   localparam logic [3:0] c_TAP_CAP_DR   = 4'h3;
   localparam logic [3:0] c_TAP_SHIFT_DR = 4'h4;
   localparam logic [3:0] c_TAP_EX1_DR   = 4'h5;
   localparam logic [3:0] c_TAP_PAUSE_DR = 4'h6;
   localparam logic [3:0] c_TAP_EX2_DR   = 4'h7;
   localparam logic [3:0] c_TAP_UPD_DR   = 4'h8;
   localparam logic [3:0] c_TAP_SEL_IR   = 4'h9;
   localparam logic [3:0] c_TAP_CAP_IR   = 4'hA;
   localparam logic [3:0] c_TAP_SHIFT_IR = 4'hB;
   localparam logic [3:0] c_TAP_EX1_IR   = 4'hC;
   localparam logic [3:0] c_TAP_PAUSE_IR = 4'hD;
   localparam logic [3:0] c_TAP_EX2_IR   = 4'hE;
   localparam logic [3:0] c_TAP_UPD_IR   = 4'hF;

   // Command opcodes
   localparam logic [1:0] c_OP_RESET    = 2'b00;
   localparam logic [1:0] c_OP_SHIFT_IR = 2'b01;
   localparam logic [1:0] c_OP_SHIFT_DR = 2'b10;
   localparam logic [1:0] c_OP_IDLE     = 2'b11;

   // Sequencer phases; each value names the TCK interval being driven
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_PRE   = 3'd1,
      ST_SHIFT = 3'd2,
      ST_POST  = 3'd3,
      ST_WAIT  = 3'd4,
      ST_DONE  = 3'd5
   } fsm_t;

   // IEEE 1149.1 TAP controller transition on one TCK rising edge
   function automatic logic [3:0] tap_next(input logic [3:0] s, input logic t);
      logic [3:0] n;
      case (s)
         c_TAP_TLR:      n = t ? c_TAP_TLR    : c_TAP_RTI;
         c_TAP_RTI:      n = t ? c_TAP_SEL_DR : c_TAP_RTI;
         c_TAP_SEL_DR:   n = t ? c_TAP_SEL_IR : c_TAP_CAP_DR;
         c_TAP_CAP_DR:   n = t ? c_TAP_EX1_DR : c_TAP_SHIFT_DR;
         c_TAP_SHIFT_DR: n = t ? c_TAP_EX1_DR : c_TAP_SHIFT_DR;
         c_TAP_EX1_DR:   n = t ? c_TAP_UPD_DR : c_TAP_PAUSE_DR;
         c_TAP_PAUSE_DR: n = t ? c_TAP_EX2_DR : c_TAP_PAUSE_DR;
         c_TAP_EX2_DR:   n = t ? c_TAP_UPD_DR : c_TAP_SHIFT_DR;
         c_TAP_UPD_DR:   n = t ? c_TAP_SEL_DR : c_TAP_RTI;
         c_TAP_SEL_IR:   n = t ? c_TAP_TLR    : c_TAP_CAP_IR;
         c_TAP_CAP_IR:   n = t ? c_TAP_EX1_IR : c_TAP_SHIFT_IR;
         c_TAP_SHIFT_IR: n = t ? c_TAP_EX1_IR : c_TAP_SHIFT_IR;
         c_TAP_EX1_IR:   n = t ? c_TAP_UPD_IR : c_TAP_PAUSE_IR;
         c_TAP_PAUSE_IR: n = t ? c_TAP_EX2_IR : c_TAP_PAUSE_IR;
         c_TAP_EX2_IR:   n = t ? c_TAP_UPD_IR : c_TAP_SHIFT_IR;
         default:        n = t ? c_TAP_SEL_DR : c_TAP_RTI;
      endcase
      return n;
   endfunction

endpackage
`default_nettype wire

// File: rtl/tap_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : tap_sequencer_if
//  Purpose  : Command/response bundle between a requester and tap_sequencer.
//  Revision : 1.0  initial release
// ============================================================================
interface tap_sequencer_if;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [1:0]  cmd_op;
   logic [4:0]  cmd_len;
   logic [31:0] cmd_data;
   logic        rsp_valid;
   logic [31:0] rsp_data;

   modport master (
      output cmd_valid, cmd_op, cmd_len, cmd_data,
      input  cmd_ready, rsp_valid, rsp_data
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_len, cmd_data,
      output cmd_ready, rsp_valid, rsp_data
   );
endinterface
`default_nettype wire

// File: rtl/tap_state_mirror.sv
`default_nettype none
// ============================================================================
//  Module   : tap_state_mirror
//  Purpose  : Tracks the state of the driven TAP controller from the TMS
//             value currently presented to it.
//  Revision : 1.0  initial release
// ============================================================================
module tap_state_mirror
   import tap_pkg::*;
(
   input  wire logic       clk,
   input  wire logic       TRST_N,
   input  wire logic       i_tms,
   output logic [3:0]      o_tap_state
);

   logic [3:0] r_state;

   // Advance the mirror exactly as the target TAP does on each TCK edge
   always_ff @(posedge clk or negedge TRST_N) begin
      if (!TRST_N) r_state <= c_TAP_TLR;
      else         r_state <= tap_next(r_state, i_tms);
   end

   assign o_tap_state = r_state;

endmodule
`default_nettype wire

// File: rtl/tap_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tap_sequencer
//  Purpose  : Turns RESET / SHIFT_IR / SHIFT_DR / IDLE commands into
//             registered TMS/TDI sequences and captures TDO while shifting.
//  Revision : 1.0  initial release
// ============================================================================
module tap_sequencer
   import tap_pkg::*;
#(
   parameter int MAX_LEN = 32
) (
   input  wire logic          clk,
   input  wire logic          TRST_N,
   tap_sequencer_if.slave     bus,
   output logic               tms,
   output logic               tdi,
   input  wire logic          tdo,
   output logic [3:0]         tap_state
);

   localparam logic [4:0] c_LEN_MAX = 5'(MAX_LEN - 1);

   fsm_t        r_fsm, w_fsm_nxt;
   logic [1:0]  r_op;
   logic [4:0]  r_len, r_cnt, w_cnt_nxt, w_len_in;
   logic [31:0] r_data, r_cap, r_rsp_data;
   logic [4:0]  r_cap_idx;
   logic [5:0]  r_pre_bits, w_pre_bits_nxt, w_pre_bits_ld;
   logic [2:0]  r_pre_cnt, w_pre_cnt_nxt, w_pre_cnt_ld;
   logic        r_tms, r_tdi, r_ready, r_rsp_valid;
   logic        w_tms_nxt, w_tdi_nxt, w_accept, w_bad, w_is_shift, w_capture;
   logic [3:0]  w_tap_state;

   tap_state_mirror u_mirror (
      .clk         (clk),
      .TRST_N      (TRST_N),
      .i_tms       (r_tms),
      .o_tap_state (w_tap_state)
   );

   assign w_len_in   = (bus.cmd_len > c_LEN_MAX) ? c_LEN_MAX : bus.cmd_len;
   assign w_is_shift = (r_op == c_OP_SHIFT_IR) || (r_op == c_OP_SHIFT_DR);
   assign w_capture  = (w_tap_state == c_TAP_SHIFT_IR) || (w_tap_state == c_TAP_SHIFT_DR);

   // Entry TMS pattern (LSB first) for the offered op, with a leading 0 when leaving Test-Logic-Reset
   always_comb begin
      w_pre_bits_ld = 6'b000000;
      w_pre_cnt_ld  = 3'd0;
      case (bus.cmd_op)
         c_OP_RESET:    begin w_pre_bits_ld = 6'b011111; w_pre_cnt_ld = 3'd6; end
         c_OP_SHIFT_IR: begin w_pre_bits_ld = 6'b000011; w_pre_cnt_ld = 3'd4; end
         c_OP_SHIFT_DR: begin w_pre_bits_ld = 6'b000001; w_pre_cnt_ld = 3'd3; end
         default:       ;
      endcase
      if ((w_tap_state == c_TAP_TLR) && (bus.cmd_op != c_OP_RESET)) begin
         w_pre_bits_ld = {w_pre_bits_ld[4:0], 1'b0};
         w_pre_cnt_ld  = w_pre_cnt_ld + 3'd1;
      end
   end

   // Next phase and counters, then the TMS/TDI to present during that phase
   always_comb begin
      w_fsm_nxt      = r_fsm;
      w_cnt_nxt      = r_cnt;
      w_pre_bits_nxt = r_pre_bits;
      w_pre_cnt_nxt  = r_pre_cnt;
      w_accept       = 1'b0;
      w_bad          = 1'b0;
      case (r_fsm)
         ST_IDLE: begin
            if (bus.cmd_valid && r_ready) begin
               w_accept       = 1'b1;
               w_cnt_nxt      = 5'd0;
               w_pre_bits_nxt = w_pre_bits_ld;
               w_pre_cnt_nxt  = w_pre_cnt_ld;
               w_fsm_nxt      = (w_pre_cnt_ld != 3'd0) ? ST_PRE : ST_WAIT;
            end
         end
         ST_PRE: begin
            if (r_pre_cnt <= 3'd1) begin
               w_pre_cnt_nxt = 3'd0;
               w_cnt_nxt     = 5'd0;
               if (r_op == c_OP_RESET)     w_fsm_nxt = ST_DONE;
               else if (r_op == c_OP_IDLE) w_fsm_nxt = ST_WAIT;
               else                        w_fsm_nxt = ST_SHIFT;
            end else begin
               w_pre_bits_nxt = r_pre_bits >> 1;
               w_pre_cnt_nxt  = r_pre_cnt - 3'd1;
            end
         end
         ST_SHIFT: begin
            if (r_cnt == r_len) begin
               w_fsm_nxt = ST_POST;
               w_cnt_nxt = 5'd0;
            end else begin
               w_cnt_nxt = r_cnt + 5'd1;
            end
         end
         ST_POST: begin
            if (r_cnt == 5'd0) begin
               w_cnt_nxt = 5'd1;
            end else begin
               w_fsm_nxt = ST_DONE;
               w_cnt_nxt = 5'd0;
            end
         end
         ST_WAIT: begin
            if (r_cnt == r_len) begin
               w_fsm_nxt = ST_DONE;
               w_cnt_nxt = 5'd0;
            end else begin
               w_cnt_nxt = r_cnt + 5'd1;
            end
         end
         ST_DONE: w_fsm_nxt = ST_IDLE;
         default: begin
            w_fsm_nxt = ST_IDLE;
            w_bad     = 1'b1;
         end
      endcase

      w_tms_nxt = 1'b0;
      w_tdi_nxt = 1'b0;
      case (w_fsm_nxt)
         ST_PRE:   w_tms_nxt = w_pre_bits_nxt[0];
         ST_SHIFT: begin
            w_tms_nxt = (w_cnt_nxt == r_len);
            w_tdi_nxt = r_data[w_cnt_nxt];
         end
         ST_POST:  w_tms_nxt = (w_cnt_nxt == 5'd0);
         default:  ;
      endcase
      if (w_bad) w_tms_nxt = 1'b1;
   end

   // Phase register and its counters
   always_ff @(posedge clk or negedge TRST_N) begin
      if (!TRST_N) begin
         r_fsm      <= ST_IDLE;
         r_cnt      <= 5'd0;
         r_pre_bits <= 6'd0;
         r_pre_cnt  <= 3'd0;
      end else begin
         r_fsm      <= w_fsm_nxt;
         r_cnt      <= w_cnt_nxt;
         r_pre_bits <= w_pre_bits_nxt;
         r_pre_cnt  <= w_pre_cnt_nxt;
      end
   end

   // Registered pin and handshake outputs for the upcoming TCK interval
   always_ff @(posedge clk or negedge TRST_N) begin
      if (!TRST_N) begin
         r_tms       <= 1'b1;
         r_tdi       <= 1'b0;
         r_ready     <= 1'b0;
         r_rsp_valid <= 1'b0;
      end else begin
         r_tms       <= w_tms_nxt;
         r_tdi       <= w_tdi_nxt;
         r_ready     <= (w_fsm_nxt == ST_IDLE);
         r_rsp_valid <= (w_fsm_nxt == ST_DONE) && w_is_shift;
      end
   end

   // Command latch, TDO capture while the TAP sits in a Shift state, response hold
   always_ff @(posedge clk or negedge TRST_N) begin
      if (!TRST_N) begin
         r_op       <= c_OP_RESET;
         r_len      <= 5'd0;
         r_data     <= 32'd0;
         r_cap      <= 32'd0;
         r_cap_idx  <= 5'd0;
         r_rsp_data <= 32'd0;
      end else begin
         if (w_accept) begin
            r_op      <= bus.cmd_op;
            r_len     <= w_len_in;
            r_data    <= bus.cmd_data;
            r_cap     <= 32'd0;
            r_cap_idx <= 5'd0;
         end else if (w_capture) begin
            r_cap[r_cap_idx] <= tdo;
            r_cap_idx        <= r_cap_idx + 5'd1;
         end
         if ((w_fsm_nxt == ST_DONE) && w_is_shift) r_rsp_data <= r_cap;
      end
   end

   assign tms           = r_tms;
   assign tdi           = r_tdi;
   assign tap_state     = w_tap_state;
   assign bus.cmd_ready = r_ready;
   assign bus.rsp_valid = r_rsp_valid;
   assign bus.rsp_data  = r_rsp_data;

endmodule
`default_nettype wire
